// File: rtl/ppu_pkg.sv
// Shared PPU / LCD frame-store types and geometry.
// Frame store holds two banks of 160x144 2-bit pixels packed 4 per byte.
package ppu_pkg;

  typedef enum logic [1:0] {PPU_HBLANK, PPU_VBLANK, PPU_OAM_SCAN, PPU_DRAW} ppu_mode_t;

  localparam int H_PIXELS       = 160;
  localparam int V_LINES        = 144;
  localparam int PX_PER_B       = 4;
  localparam int BYTES_PER_LINE = H_PIXELS / PX_PER_B;
  localparam int BANK_BYTES     = BYTES_PER_LINE * V_LINES;

  typedef enum logic [1:0] {WAIT_SYNC, ACTIVE, HBLANK, VBLANK} lcd_writer_state_t;

  typedef struct packed {
    logic [13:0] addr;
    logic [7:0]  data;
  } mem_wr_t;

  // y*40 as shift-and-add; 143*40 = 5720 fits in 13 bits.
  function automatic logic [12:0] line_base(input logic [7:0] y);
    return ({5'b0, y} << 5) + ({5'b0, y} << 3);
  endfunction

endpackage

// File: rtl/lcd_frame_writer_px_packer.sv
// Packs 2-bit pixels MSB-first into bytes; emits a full byte on the 4th pixel
// or a left-justified, zero-padded partial byte on flush.
module px_packer
  import ppu_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       clr,
  input  logic       push,
  input  logic [1:0] pix,
  input  logic       flush,
  output logic       byte_vld,
  output logic [7:0] byte_data
);

  logic [7:0] sr, sr_nxt;
  logic [1:0] ph, ph_nxt;

  // The pixel of this cycle is folded in before a flush looks at the phase.
  always_comb begin
    sr_nxt    = push ? {sr[5:0], pix} : sr;
    ph_nxt    = push ? ph + 2'd1 : ph;
    byte_vld  = 1'b0;
    byte_data = sr_nxt;
    if (push && ph == 2'd3) begin
      byte_vld = 1'b1;
    end else if (flush && ph_nxt != 2'd0) begin
      byte_vld = 1'b1;
      case (ph_nxt)
        2'd1:    byte_data = {sr_nxt[1:0], 6'b0};
        2'd2:    byte_data = {sr_nxt[3:0], 4'b0};
        default: byte_data = {sr_nxt[5:0], 2'b0};
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sr <= '0;
      ph <= '0;
    end else if (clr) begin
      sr <= '0;
      ph <= '0;
    end else begin
      sr <= sr_nxt;
      ph <= ph_nxt;
    end
  end

endmodule

// File: rtl/lcd_frame_writer.sv
// PPU pixel stream to double-buffered packed frame store; swaps banks at
// vblank entry and flags malformed lines/frames in a sticky error bit.
module lcd_frame_writer
  import ppu_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [1:0]  pixel_in,
  input  logic        pixel_valid_in,
  input  logic        hblank_in,
  input  logic        vblank_in,
  output logic [13:0] mem_addr_out,
  output logic [7:0]  mem_data_out,
  output logic        mem_we_out,
  output logic        front_bank_out,
  output logic        frame_done_out,
  output logic        line_err_out
);

  localparam logic [7:0] X_MAX  = 8'(H_PIXELS);
  localparam logic [7:0] Y_LAST = 8'(V_LINES - 1);

  logic [1:0] rst_sync;
  logic       rst_n;

  // Assert asynchronously, release two clocks later.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  lcd_writer_state_t state, state_nxt;
  logic [7:0] x, y, x_upd, y_nxt;
  logic       hblank_q, vblank_q;
  logic       hb_rise, hb_fall, vb_rise, vb_fall;
  logic       accept, line_end, frame_end, err_set;
  logic       pk_vld;
  logic [7:0] pk_data;
  logic [5:0] byte_idx;
  mem_wr_t    wr_nxt;

  assign hb_rise = hblank_in & ~hblank_q;
  assign hb_fall = ~hblank_in & hblank_q;
  assign vb_rise = vblank_in & ~vblank_q;
  assign vb_fall = ~vblank_in & vblank_q;

  assign accept = (state == ACTIVE) && pixel_valid_in && (x < X_MAX);
  assign x_upd  = x + {7'b0, accept};

  always_comb begin
    state_nxt = state;
    y_nxt     = y;
    line_end  = 1'b0;
    frame_end = 1'b0;
    err_set   = 1'b0;
    case (state)
      WAIT_SYNC: if (vb_rise) state_nxt = VBLANK;
      ACTIVE: begin
        if (pixel_valid_in && !accept) err_set = 1'b1;
        if (vb_rise) begin
          frame_end = 1'b1;
          state_nxt = VBLANK;
          if (y != Y_LAST || x_upd != X_MAX) err_set = 1'b1;
        end else if (hb_rise) begin
          line_end  = 1'b1;
          state_nxt = HBLANK;
          if (x_upd != X_MAX) err_set = 1'b1;
        end
      end
      HBLANK: begin
        if (pixel_valid_in) err_set = 1'b1;
        if (vb_rise) begin
          frame_end = 1'b1;
          state_nxt = VBLANK;
          if (y != Y_LAST) err_set = 1'b1;
        end else if (hb_fall) begin
          // Lines past the last one stay in HBLANK so their pixels drop as errors.
          if (y == Y_LAST) err_set = 1'b1;
          else begin
            state_nxt = ACTIVE;
            y_nxt     = y + 8'd1;
          end
        end
      end
      VBLANK: begin
        if (vb_fall) begin
          state_nxt = ACTIVE;
          y_nxt     = 8'd0;
        end
      end
      default: state_nxt = WAIT_SYNC;
    endcase
  end

  px_packer u_packer (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n),
    .clr       (state != ACTIVE),
    .push      (accept),
    .pix       (pixel_in),
    .flush     (line_end),
    .byte_vld  (pk_vld),
    .byte_data (pk_data)
  );

  // x_upd-1 is the last pixel landed; its byte is the one being written.
  assign byte_idx    = 6'((x_upd - 8'd1) >> 2);
  assign wr_nxt.addr = (front_bank_out ? 14'd0 : 14'(BANK_BYTES))
                     + {1'b0, line_base(y)} + {8'b0, byte_idx};
  assign wr_nxt.data = pk_data;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state          <= WAIT_SYNC;
      x              <= '0;
      y              <= '0;
      hblank_q       <= 1'b1;
      vblank_q       <= 1'b1;
      front_bank_out <= 1'b0;
      frame_done_out <= 1'b0;
      line_err_out   <= 1'b0;
      mem_we_out     <= 1'b0;
      mem_addr_out   <= '0;
      mem_data_out   <= '0;
    end else begin
      state          <= state_nxt;
      y              <= y_nxt;
      x              <= (state == ACTIVE) ? x_upd : 8'd0;
      hblank_q       <= hblank_in;
      vblank_q       <= vblank_in;
      front_bank_out <= front_bank_out ^ frame_end;
      frame_done_out <= frame_end;
      line_err_out   <= line_err_out | err_set;
      mem_we_out     <= pk_vld;
      if (pk_vld) begin
        mem_addr_out <= wr_nxt.addr;
        mem_data_out <= wr_nxt.data;
      end
    end
  end

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Randomized line/frame stimulus against a line-level model of the frame store.
module tb_lcd_frame_writer;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b1;
  logic [1:0]  pixel_in = 2'd0;
  logic        pixel_valid_in = 1'b0;
  logic        hblank_in = 1'b1;
  logic        vblank_in = 1'b0;
  logic [13:0] mem_addr_out;
  logic [7:0]  mem_data_out;
  logic        mem_we_out, front_bank_out, frame_done_out, line_err_out;

  lcd_frame_writer dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .pixel_in       (pixel_in),
    .pixel_valid_in (pixel_valid_in),
    .hblank_in      (hblank_in),
    .vblank_in      (vblank_in),
    .mem_addr_out   (mem_addr_out),
    .mem_data_out   (mem_data_out),
    .mem_we_out     (mem_we_out),
    .front_bank_out (front_bank_out),
    .frame_done_out (frame_done_out),
    .line_err_out   (line_err_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {int addr; int data;} wr_t;

  int  checks = 0, errors = 0;
  wr_t exp_q[$];
  wr_t mon_e;
  int  wr_cnt = 0, done_cnt = 0;
  int  la0 = 0, ld0 = 0, la1 = 0, ld1 = 0;
  logic prev_done = 1'b0;

  // Frame-level model state
  bit m_in_frame = 0, m_front = 0, m_err = 0;
  int m_lines = 0, m_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
  endtask

  always @(posedge clk_in) begin
    #1;
    if (mem_we_out === 1'b1) begin
      wr_cnt++;
      la0 = la1; ld0 = ld1; la1 = int'(mem_addr_out); ld1 = int'(mem_data_out);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write", mem_addr_out, mem_data_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr_out), mon_e.addr);
        chk("wr_data", 32'(mem_data_out), mon_e.data);
      end
    end
    if (frame_done_out === 1'b1) begin
      done_cnt++;
      chk("done_width", 32'(prev_done), 0);
    end
    prev_done = frame_done_out;
  end

  // Expected writes for one line: full bytes, plus a padded tail if the line ends.
  function automatic void model_line(input logic [1:0] px[$], input bit ends);
    int acc, nb, base;
    logic [7:0] b;
    if (!m_in_frame) return;
    acc  = (px.size() > 160) ? 160 : px.size();
    nb   = ends ? (acc + 3) / 4 : acc / 4;
    base = (m_front ? 0 : 5760) + m_lines * 40;
    for (int k = 0; k < nb; k++) begin
      b = 8'h00;
      for (int j = 0; j < 4; j++)
        if (4 * k + j < acc) b[7 - 2 * j -: 2] = px[4 * k + j];
      exp_q.push_back('{base + k, int'(b)});
    end
    if (ends) begin
      if (px.size() != 160) m_err = 1;
      m_lines++;
    end
  endfunction

  // mode 0: pixel = x%4, 1: random, 2: all 2'b11
  task automatic drive_pixels(input int n, input int mode, input bit ends, input bit coinc);
    logic [1:0] px[$];
    for (int i = 0; i < n; i++)
      px.push_back(mode == 0 ? 2'(i % 4) : mode == 2 ? 2'b11 : 2'($urandom_range(3)));
    model_line(px, ends);
    hblank_in = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(7) == 0) begin
        pixel_valid_in = 1'b0;
        tick();
      end
      pixel_in = px[i];
      pixel_valid_in = 1'b1;
      if (ends && coinc && i == n - 1) hblank_in = 1'b1;
      tick();
    end
    pixel_valid_in = 1'b0;
    if (ends) hblank_in = 1'b1;
    repeat (3) tick();
  endtask

  task automatic do_vblank();
    if (m_in_frame) begin
      m_front = ~m_front;
      m_done++;
      if (m_lines != 144) m_err = 1;
    end
    m_in_frame = 1;
    m_lines = 0;
    vblank_in = 1'b1;
    repeat (3) tick();
    vblank_in = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_reset();
    tick();
    rst_n_in = 1'b0;
    #1;
    chk("rst_we", 32'(mem_we_out), 0);
    chk("rst_addr", 32'(mem_addr_out), 0);
    chk("rst_data", 32'(mem_data_out), 0);
    chk("rst_front", 32'(front_bank_out), 0);
    chk("rst_done", 32'(frame_done_out), 0);
    chk("rst_err", 32'(line_err_out), 0);
    m_in_frame = 0; m_lines = 0; m_front = 0; m_err = 0;
    exp_q.delete();
    hblank_in = 1'b1; vblank_in = 1'b0; pixel_valid_in = 1'b0;
    repeat (3) tick();
    rst_n_in = 1'b1;
    repeat (4) tick();
  endtask

  task automatic checkpoint(input string tag);
    chk({tag, "_front"}, 32'(front_bank_out), 32'(m_front));
    chk({tag, "_err"}, 32'(line_err_out), 32'(m_err));
    chk({tag, "_done"}, done_cnt, m_done);
    chk({tag, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Pixels before the first vblank are ignored without error.
    drive_pixels(160, 1, 1, 0);
    chk("presync_writes", wr_cnt, 0);
    chk("presync_err", 32'(line_err_out), 0);
    do_vblank();
    checkpoint("sync");

    // Frame 1: x%4 pattern into bank 1.
    wr_cnt = 0;
    for (int l = 0; l < 144; l++) drive_pixels(160, 0, 1, 0);
    do_vblank();
    checkpoint("f1");
    chk("f1_writes", wr_cnt, 5760);
    chk("f1_last_addr", la1, 11519);
    chk("f1_last_data", ld1, 8'h1B);
    chk("f1_front_lit", 32'(front_bank_out), 1);
    chk("f1_err_lit", 32'(line_err_out), 0);

    // Frame 2: random pixels into bank 0, hblank coincident with last pixel on some lines.
    for (int l = 0; l < 144; l++) drive_pixels(160, 1, 1, (l == 10 || l == 143));
    do_vblank();
    checkpoint("f2");
    chk("f2_front_lit", 32'(front_bank_out), 0);
    chk("f2_done_lit", done_cnt, 2);
    chk("f2_err_lit", 32'(line_err_out), 0);

    // Frame 3: short line, long line, then reset mid line 70.
    drive_pixels(160, 1, 1, 0);
    drive_pixels(160, 1, 1, 0);
    drive_pixels(6, 2, 1, 0);
    chk("short_addr0", la0, 5760 + 80);
    chk("short_data0", ld0, 8'hFF);
    chk("short_addr1", la1, 5760 + 81);
    chk("short_data1", ld1, 8'hF0);
    chk("short_err", 32'(line_err_out), 1);
    wr_cnt = 0;
    drive_pixels(161, 1, 1, 0);
    chk("long_writes", wr_cnt, 40);
    chk("long_err", 32'(line_err_out), 1);
    for (int l = 4; l < 70; l++) drive_pixels(160, 1, 1, 0);
    drive_pixels(40, 1, 0, 0);
    checkpoint("mid");
    do_reset();

    // After reset nothing is written until the next vblank.
    wr_cnt = 0;
    drive_pixels(160, 1, 1, 0);
    chk("postrst_writes", wr_cnt, 0);
    do_vblank();
    for (int l = 0; l < 3; l++) drive_pixels(160, 1, 1, 0);
    do_vblank();
    checkpoint("trunc");
    chk("trunc_front_lit", 32'(front_bank_out), 1);
    chk("trunc_err_lit", 32'(line_err_out), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
